// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, parity bit, stop bit.
// Delivers the parallel word with parity and framing error flags and a one-cycle valid pulse.
module parity_frame_rx #(
  parameter int DATA_W = 8,
  parameter bit ODD    = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              x,
  input  logic              bit_en,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              par_err,
  output logic              frm_err,
  output logic              busy,
  output logic              z
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] dout_q;
  logic              z_q;
  logic              p_q;
  logic              valid_q;
  logic              par_err_q;
  logic              frm_err_q;
  logic              busy_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      dout_q    <= '0;
      z_q       <= 1'b0;
      p_q       <= 1'b0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (bit_en) begin
        case (state_q)
          IDLE: begin
            if (x) begin
              state_q <= DATA;
              cnt_q   <= '0;
              z_q     <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
          DATA: begin
            // Right shift: after DATA_W samples the first bit sits at position 0.
            shift_q <= {x, shift_q[DATA_W-1:1]};
            z_q     <= z_q ^ x;
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
              state_q <= PARITY;
            end
          end
          PARITY: begin
            p_q     <= x;
            state_q <= STOP;
          end
          STOP: begin
            // The stop sample never starts a new frame, even when it is 1.
            dout_q    <= shift_q;
            par_err_q <= ((z_q ^ p_q) != ODD);
            frm_err_q <= x;
            valid_q   <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dout    = dout_q;
  assign valid   = valid_q;
  assign par_err = par_err_q;
  assign frm_err = frm_err_q;
  assign busy    = busy_q;
  assign z       = z_q;

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench for parity_frame_rx: an even-parity and an odd-parity instance share
// one serial line, and every step is checked with immediate assertions.
module tb_parity_frame_rx;

  logic       clk;
  logic       reset;
  logic       x;
  logic       bit_en;
  logic [7:0] dout_e, dout_o;
  logic       valid_e, valid_o, par_err_e, par_err_o, frm_err_e, frm_err_o;
  logic       busy_e, busy_o, z_e, z_o;

  int total = 0;
  int bad   = 0;
  int vcount = 0;
  int vsnap;

  parity_frame_rx #(.DATA_W(8), .ODD(1'b0)) dut_e (
    .clk(clk), .reset(reset), .x(x), .bit_en(bit_en),
    .dout(dout_e), .valid(valid_e), .par_err(par_err_e), .frm_err(frm_err_e),
    .busy(busy_e), .z(z_e)
  );

  parity_frame_rx #(.DATA_W(8), .ODD(1'b1)) dut_o (
    .clk(clk), .reset(reset), .x(x), .bit_en(bit_en),
    .dout(dout_o), .valid(valid_o), .par_err(par_err_o), .frm_err(frm_err_o),
    .busy(busy_o), .z(z_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid_e === 1'b1) vcount++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    x      = b;
    bit_en = 1'b1;
    @(posedge clk);
    #1;
    bit_en = 1'b0;
    x      = 1'b0;
  endtask

  // Start bit, eight data bits LSB first and the parity bit; the stop bit is sent by the caller.
  task automatic send_body(input logic [7:0] data, input logic p, input int gap);
    send_bit(1'b1);
    idle(gap);
    for (int i = 0; i < 8; i++) begin
      send_bit(data[i]);
      idle(gap);
    end
    send_bit(p);
    idle(gap);
  endtask

  task automatic chk_frame(input string tag, input logic [7:0] exp_dout,
                           input logic pe_even, input logic pe_odd, input logic fe);
    chk({tag, ".valid_e"}, valid_e, 1'b1);
    chk({tag, ".valid_o"}, valid_o, 1'b1);
    chk({tag, ".dout_e"}, dout_e, exp_dout);
    chk({tag, ".dout_o"}, dout_o, exp_dout);
    chk({tag, ".par_err_e"}, par_err_e, pe_even);
    chk({tag, ".par_err_o"}, par_err_o, pe_odd);
    chk({tag, ".frm_err_e"}, frm_err_e, fe);
    chk({tag, ".busy_e"}, busy_e, 1'b0);
  endtask

  initial begin
    reset  = 1'b0;
    x      = 1'b0;
    bit_en = 1'b0;
    idle(2);
    chk("rst.dout", dout_e, 8'h00);
    chk("rst.valid", valid_e, 1'b0);
    chk("rst.par_err", par_err_e, 1'b0);
    chk("rst.frm_err", frm_err_e, 1'b0);
    chk("rst.busy", busy_e, 1'b0);
    chk("rst.z", z_e, 1'b0);
    reset = 1'b1;
    idle(1);

    // Clean A5 frame, bit_en every cycle, walked bit by bit.
    send_bit(1'b1);
    chk("a5.busy_after_start", busy_e, 1'b1);
    chk("a5.z_after_start", z_e, 1'b0);
    send_bit(1'b1);
    chk("a5.z_after_bit0", z_e, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("a5.z_after_bit2", z_e, 1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("a5.valid_before_parity", valid_e, 1'b0);
    send_bit(1'b0);
    chk("a5.z_in_stop", z_e, 1'b0);
    chk("a5.busy_in_stop", busy_e, 1'b1);
    send_bit(1'b0);
    chk_frame("a5", 8'hA5, 1'b0, 1'b1, 1'b0);
    idle(1);
    chk("a5.valid_cleared", valid_e, 1'b0);
    chk("a5.dout_held", dout_e, 8'hA5);

    // Parity error on the even instance, accepted by the odd instance.
    send_body(8'hA5, 1'b1, 0);
    send_bit(1'b0);
    chk_frame("a5p1", 8'hA5, 1'b1, 1'b0, 1'b0);
    idle(1);

    // Framing error: stop=1 must not be taken as a start bit.
    send_body(8'h01, 1'b1, 0);
    chk("f01.z_in_stop", z_e, 1'b1);
    send_bit(1'b1);
    chk_frame("f01", 8'h01, 1'b0, 1'b1, 1'b1);
    send_bit(1'b0);
    chk("f01.busy_after", busy_e, 1'b0);
    chk("f01.valid_after", valid_e, 1'b0);
    idle(2);
    chk("f01.busy_idle", busy_e, 1'b0);

    // Back-to-back FF then 00 with bit_en every third cycle.
    vsnap = vcount;
    send_body(8'hFF, 1'b0, 2);
    send_bit(1'b0);
    chk_frame("ff", 8'hFF, 1'b0, 1'b1, 1'b0);
    idle(1);
    chk("ff.valid_one_cycle", valid_e, 1'b0);
    idle(1);
    send_body(8'h00, 1'b0, 2);
    send_bit(1'b0);
    chk_frame("00", 8'h00, 1'b0, 1'b1, 1'b0);
    idle(1);
    chk("00.valid_one_cycle", valid_e, 1'b0);
    chk("b2b.pulse_count", vcount - vsnap, 2);

    // Load a nonzero word, then reset in the middle of the next frame.
    send_body(8'hA5, 1'b0, 0);
    send_bit(1'b0);
    chk("pre_rst.dout", dout_e, 8'hA5);
    idle(1);
    vsnap = vcount;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("mid.busy_before_rst", busy_e, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid.dout", dout_e, 8'h00);
    chk("mid.busy", busy_e, 1'b0);
    chk("mid.z", z_e, 1'b0);
    chk("mid.valid", valid_e, 1'b0);
    idle(1);
    reset = 1'b1;
    idle(3);
    chk("mid.no_pulse", vcount - vsnap, 0);
    chk("mid.busy_after_release", busy_e, 1'b0);
    send_body(8'h3C, 1'b0, 0);
    send_bit(1'b0);
    chk_frame("3c", 8'h3C, 1'b0, 1'b1, 1'b0);
    idle(1);

    // Idle line for 50 samples.
    vsnap = vcount;
    for (int i = 0; i < 50; i++) begin
      send_bit(1'b0);
      if (busy_e !== 1'b0) chk("idle.busy", busy_e, 1'b0);
    end
    chk("idle.busy_final", busy_e, 1'b0);
    chk("idle.no_pulse", vcount - vsnap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
